// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, auxiliary writes queue in a FIFO.
// Optional WB_ARB_BYPASS_EN: an auxiliary beat on an idle port with an empty FIFO is written directly.
module wb_port_arbiter #(
    parameter int unsigned AUX_DEPTH    = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [2:0]  wb_addr,
    input  logic [15:0] wb_data,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [2:0]  aux_addr,
    input  logic [15:0] aux_data,
    output logic        rf_we,
    output logic [2:0]  rf_addr,
    output logic [15:0] rf_data,
    output logic        stall_req
);

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned PTR_W  = (AUX_DEPTH > 1) ? $clog2(AUX_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(AUX_DEPTH + 1);
    localparam int unsigned STV_W  = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_beat_t;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    wr_beat_t          mem [AUX_DEPTH];
    wr_beat_t          head;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [STV_W-1:0]  starve;
    logic [STV_W-1:0]  starve_next;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic              bypass;
    logic              sel_we;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(AUX_DEPTH));
    assign head      = mem[rd_ptr];
    assign aux_ready = !full && !reset;
    assign push      = aux_valid && aux_ready && !bypass;
    assign rf_we     = sel_we && !reset;
    assign stall_req = (state == STALL);

    // Port mux, pop decision, starvation tracking and next state
    always_comb begin
        state_next  = state;
        starve_next = starve;
        pop         = 1'b0;
        bypass      = 1'b0;
        sel_we      = 1'b0;
        rf_addr     = wb_addr;
        rf_data     = wb_data;

        case (state)
            IDLE: begin
                if (wb_we) begin
                    sel_we = 1'b1;
                end else if (!empty) begin
                    sel_we  = 1'b1;
                    rf_addr = head.addr;
                    rf_data = head.data;
                    pop     = 1'b1;
                end
`ifdef WB_ARB_BYPASS_EN
                else if (aux_valid && !reset) begin
                    sel_we  = 1'b1;
                    rf_addr = aux_addr;
                    rf_data = aux_data;
                    bypass  = 1'b1;
                end
`endif
            end
            STALL: begin
                // upstream holds wb_* frozen; it is written in the next IDLE cycle
                sel_we      = !empty;
                rf_addr     = head.addr;
                rf_data     = head.data;
                pop         = !empty;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (pop || empty) begin
            starve_next = '0;
        end else if (state == IDLE && wb_we) begin
            if (starve < STV_W'(STARVE_LIMIT)) begin
                starve_next = starve + STV_W'(1);
            end
            if (starve_next == STV_W'(STARVE_LIMIT) && starve != STV_W'(STARVE_LIMIT)) begin
                state_next = STALL;
            end
        end
    end

    // Control state and FIFO pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            starve <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state  <= state_next;
            starve <= starve_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are meaningless while count is zero, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {aux_addr, aux_data};
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: per-cycle status expectations plus ordered write expectations.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_we;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        aux_valid;
    logic        aux_ready;
    logic [2:0]  aux_addr;
    logic [15:0] aux_data;
    logic        rf_we;
    logic [2:0]  rf_addr;
    logic [15:0] rf_data;
    logic        stall_req;

`ifdef WB_ARB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    typedef struct packed {
        logic we;
        logic stall;
        logic ready;
    } st_t;

    typedef struct packed {
        logic [2:0]  addr;
        logic [15:0] data;
    } wr_t;

    st_t         st_q[$];
    wr_t         wr_q[$];
    logic [15:0] shadow [8];
    int          errors = 0;
    int          checks = 0;
    bit          done = 1'b0;

    wb_port_arbiter #(.AUX_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .aux_valid (aux_valid),
        .aux_ready (aux_ready),
        .aux_addr  (aux_addr),
        .aux_data  (aux_data),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic rst, input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic av, input logic [2:0] aa, input logic [15:0] ad,
                       input logic ewe, input logic estall, input logic erdy);
        st_t s;
        @(posedge clk);
        #1;
        reset     = rst;
        wb_we     = we;
        wb_addr   = wa;
        wb_data   = wd;
        aux_valid = av;
        aux_addr  = aa;
        aux_data  = ad;
        s.we      = ewe;
        s.stall   = estall;
        s.ready   = erdy;
        st_q.push_back(s);
    endtask

    task automatic expw(input logic [2:0] a, input logic [15:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wr_q.push_back(w);
    endtask

    task automatic idle(input logic ewe);
        cyc(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, ewe, 1'b0, 1'b1);
    endtask

    // Stimulus: directed cycles with hand-computed expectations
    initial begin
        reset     = 1'b1;
        wb_we     = 1'b0;
        wb_addr   = 3'd0;
        wb_data   = 16'h0;
        aux_valid = 1'b0;
        aux_addr  = 3'd0;
        aux_data  = 16'h0;

        cyc(1'b1, 1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0);
        expw(3'd3, 16'hBEEF);
        cyc(1'b0, 1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b1);

        expw(3'd5, 16'h1234);
        cyc(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 16'h1234, BYP, 1'b0, 1'b1);
        idle(~BYP);
        idle(1'b0);

        expw(3'd1, 16'h1000);
        cyc(1'b0, 1'b1, 3'd1, 16'h1000, 1'b1, 3'd4, 16'hA001, 1'b1, 1'b0, 1'b1);
        expw(3'd1, 16'h1001);
        cyc(1'b0, 1'b1, 3'd1, 16'h1001, 1'b1, 3'd6, 16'hA002, 1'b1, 1'b0, 1'b1);
        expw(3'd1, 16'h1002);
        cyc(1'b0, 1'b1, 3'd1, 16'h1002, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b0);
        expw(3'd1, 16'h1003);
        cyc(1'b0, 1'b1, 3'd1, 16'h1003, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b0);
        expw(3'd1, 16'h1004);
        cyc(1'b0, 1'b1, 3'd1, 16'h1004, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b0);
        expw(3'd4, 16'hA001);
        cyc(1'b0, 1'b1, 3'd1, 16'h1005, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1, 1'b0);
        expw(3'd1, 16'h1005);
        cyc(1'b0, 1'b1, 3'd1, 16'h1005, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b1);
        expw(3'd6, 16'hA002);
        idle(1'b1);
        idle(1'b0);

        expw(3'd2, 16'h0001);
        expw(3'd2, 16'h0002);
        cyc(1'b0, 1'b1, 3'd2, 16'h0001, 1'b1, 3'd2, 16'h0002, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b0);

        expw(3'd0, 16'h0BAD);
        cyc(1'b0, 1'b1, 3'd0, 16'h0BAD, 1'b1, 3'd3, 16'hC001, 1'b1, 1'b0, 1'b1);
        expw(3'd0, 16'h0BAE);
        cyc(1'b0, 1'b1, 3'd0, 16'h0BAE, 1'b1, 3'd3, 16'hC002, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 3'd0, 16'h0BAF, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);

        expw(3'd7, 16'hA5A5);
        cyc(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 16'hA5A5, BYP, 1'b0, 1'b1);
        idle(~BYP);
        idle(1'b0);

        @(posedge clk);
        #1;
        done = 1'b1;
    end

    // Monitor: pops expectations and compares against the DUT away from the active edge
    initial begin
        st_t s;
        wr_t w;
        do begin
            @(negedge clk);
            if (!done) begin
                if (st_q.size() > 0) begin
                    s = st_q.pop_front();
                    checks++;
                    if ({rf_we, stall_req, aux_ready} !== s) begin
                        errors++;
                        $display("FAIL status @%0t: rf_we/stall_req/aux_ready got %b%b%b want %b%b%b",
                                 $time, rf_we, stall_req, aux_ready, s.we, s.stall, s.ready);
                    end
                end
                if (rf_we === 1'b1) begin
                    checks++;
                    if (wr_q.size() == 0) begin
                        errors++;
                        $display("FAIL write @%0t: unexpected addr=%0d data=%h, want none",
                                 $time, rf_addr, rf_data);
                    end else begin
                        w = wr_q.pop_front();
                        if (rf_addr !== w.addr || rf_data !== w.data) begin
                            errors++;
                            $display("FAIL write @%0t: got addr=%0d data=%h want addr=%0d data=%h",
                                     $time, rf_addr, rf_data, w.addr, w.data);
                        end
                    end
                    shadow[rf_addr] = rf_data;
                end
            end
        end while (!done);

        checks++;
        if (wr_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected writes never appeared, want 0", wr_q.size());
        end
        checks++;
        if (shadow[2] !== 16'h0002) begin
            errors++;
            $display("FAIL collision: reg2 got %h want 0002", shadow[2]);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbiter for the single register-file write port. Sits between the writeback stage (`loadData`/`loadAddr`/`regWriteOut`) and the register file, and shares the port with an auxiliary requester such as a multi-cycle unit or debug port. Pipeline writes always pass with zero added latency. Auxiliary writes are buffered in a small FIFO and drained in idle write slots. A starvation counter forces a one-cycle pipeline stall so that queued auxiliary writes are guaranteed to retire.

## Interface
Parameters:
- `AUX_DEPTH`, default 2: auxiliary FIFO entries; power of 2, ≥2.
- `STARVE_LIMIT`, default 4: consecutive blocked cycles of a non-empty FIFO before a stall is forced; range 1–15.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `wb_we`  in  1  pipeline writeback enable.
- `wb_addr`  in  3  pipeline destination register.
- `wb_data`  in  16  pipeline write data.
- `aux_valid`  in  1  auxiliary write request.
- `aux_ready`  out  1  auxiliary beat accepted when `aux_valid & aux_ready` at a rising edge.
- `aux_addr`  in  3  auxiliary destination register.
- `aux_data`  in  16  auxiliary write data.
- `rf_we`  out  1  register-file write enable.
- `rf_addr`  out  3  register-file write address.
- `rf_data`  out  16  register-file write data.
- `stall_req`  out  1  freeze request to the pipeline, one cycle per forced slot.

## Operation
- State: FIFO (`AUX_DEPTH` × 19 bits), count, 4-bit starvation counter `starve`, FSM {IDLE, STALL}.
- `aux_ready = !full & !reset`. Dequeueing and enqueueing in the same cycle is allowed; a full FIFO accepts nothing in that cycle, even if it pops.
- Port mux, combinational from inputs and registered state:
  - IDLE with `wb_we=1`: the pipeline owns the port. `rf_*` = `wb_*`. The FIFO head waits.
  - IDLE with `wb_we=0` and FIFO non-empty: the head is driven on `rf_*` with `rf_we=1` and popped at the edge.
  - IDLE with `wb_we=0` and FIFO empty: `rf_we=0`.
  - STALL: the FIFO head owns the port and is popped. `wb_*` is ignored, because upstream holds it stable under `stall_req`, and it is written in the following IDLE cycle.
- `starve` increments at each edge in IDLE where the FIFO is non-empty and `wb_we=1`. It clears on any pop or when the FIFO is empty. It saturates at `STARVE_LIMIT`.
- FSM transitions:
  - IDLE→STALL at the edge where `starve` reaches `STARVE_LIMIT`.
  - STALL→IDLE unconditionally after one cycle. `starve` clears.
- `stall_req = (state==STALL)`, which is a registered-state output.
- Same-address collision (aux head and pipeline write to the same register): order is grant order. The later grant wins in the register file. No merging or cancellation.
- All 8 addresses, including 0, are passed through unchanged. Register-file semantics decide the effect.

## Timing
- Reset values: `rf_we=0`, `stall_req=0`, `aux_ready=0` while `reset=1`, then 1 in the first cycle after release. FIFO empty, `starve=0`, state IDLE.
- Pipeline write latency is 0: `rf_*` follows `wb_*` in the same cycle unless in STALL.
- Auxiliary latency is at least 1 cycle: a beat accepted at edge N appears on `rf_*` no earlier than cycle N→N+1.
- Worst-case auxiliary head wait is `STARVE_LIMIT`+1 cycles.
- `stall_req` is high for exactly one cycle per forced slot. Back-to-back stalls require `STARVE_LIMIT` blocked cycles between them.
- Reset asserted mid-operation: queued auxiliary beats are discarded. Outputs return to reset values asynchronously.

## Configuration
- `WB_ARB_BYPASS_EN` defined: in IDLE with FIFO empty, `wb_we=0`, and `aux_valid=1`, the auxiliary beat is written directly in the same cycle (`rf_*` = `aux_*`, `rf_we=1`) and is not enqueued. This gives auxiliary latency 0.
- Undefined: every auxiliary beat passes through the FIFO. Minimum latency is 1 cycle.

## Test plan
- Reset release with `wb_we=1, wb_addr=3, wb_data=16'hBEEF` → same cycle `rf_we=1, rf_addr=3, rf_data=16'hBEEF`. `stall_req=0` throughout.
- Aux beat (addr 5, data `16'h1234`) accepted with `wb_we=0` thereafter → written the next cycle (bypass off). FIFO then empty, `aux_ready=1`.
- Fill FIFO with 2 aux beats while `wb_we=1` → `aux_ready=0`. After 4 blocked cycles, `stall_req=1` for 1 cycle and head written. Held `wb_*` written the cycle after.
- Pipeline writes addr 2 = `16'h0001` while aux head targets addr 2 = `16'h0002`, then `wb_we=0` → final register value is `16'h0002`.
- Assert `reset` with 2 beats queued → `rf_we=0`, `aux_ready=0` immediately. After release, no stale aux writes appear.
- With `WB_ARB_BYPASS_EN` defined, idle port, aux beat (addr 7, `16'hA5A5`) → `rf_we=1, rf_addr=7` in the acceptance cycle. FIFO count stays 0.
